// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Big-endian byte-addressable data memory answering load/store
//               requests after WAIT_CYCLES wait states with a READY pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              E,
    input  logic              RW,
    input  logic [1:0]        SIZE,
    input  logic              SE,
    input  logic [ADDR_W-1:0] A,
    input  logic [31:0]       DI,
    output logic [31:0]       DO,
    output logic              READY,
    output logic              ERR,
    output logic              BUSY
);

    localparam int         c_DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] c_WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [7:0]        r_mem [0:c_DEPTH-1];
    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rw;
    logic [1:0]        r_size;
    logic              r_se;
    logic [31:0]       r_di;
    logic [31:0]       r_do;
    logic              r_ready;
    logic              r_err;
    logic              r_busy;

    logic [ADDR_W-1:0] w_addr;
    logic              w_rw;
    logic [1:0]        w_size;
    logic              w_se;
    logic              w_err;
    logic              w_go_resp;
    logic [7:0]        w_b0, w_b1, w_b2, w_b3;
    logic [31:0]       w_load;

    // With zero wait states the response is prepared from the live request.
    always_comb begin
        w_addr = r_addr;
        w_rw   = r_rw;
        w_size = r_size;
        w_se   = r_se;
        if (r_state == c_IDLE) begin
            w_addr = A;
            w_rw   = RW;
            w_size = SIZE;
            w_se   = SE;
        end
    end

    assign w_err = (w_size == 2'b11)
                 | ((w_size == 2'b01) & w_addr[0])
                 | ((w_size == 2'b10) & (|w_addr[1:0]));

    assign w_b0 = r_mem[w_addr];
    assign w_b1 = r_mem[w_addr + ADDR_W'(1)];
    assign w_b2 = r_mem[w_addr + ADDR_W'(2)];
    assign w_b3 = r_mem[w_addr + ADDR_W'(3)];

    always_comb begin
        w_load = {w_b0, w_b1, w_b2, w_b3};
        case (w_size)
            2'b00:   w_load = {{24{w_se & w_b0[7]}}, w_b0};
            2'b01:   w_load = {{16{w_se & w_b0[7]}}, w_b0, w_b1};
            default: w_load = {w_b0, w_b1, w_b2, w_b3};
        endcase
    end

    assign w_go_resp = ((r_state == c_IDLE) && E && (WAIT_CYCLES == 0))
                     || ((r_state == c_WAIT) && (r_cnt == 4'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_rw    <= 1'b0;
            r_size  <= 2'b00;
            r_se    <= 1'b0;
            r_di    <= 32'd0;
            r_do    <= 32'd0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            if (w_go_resp) begin
                r_ready <= 1'b1;
                r_err   <= w_err;
                if (w_err)
                    r_do <= 32'd0;
                else if (!w_rw)
                    r_do <= w_load;
            end
            case (r_state)
                c_IDLE: begin
                    if (E) begin
                        r_addr <= A;
                        r_rw   <= RW;
                        r_size <= SIZE;
                        r_se   <= SE;
                        r_di   <= DI;
                        r_busy <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= c_RESP;
                        end else begin
                            r_cnt   <= c_WAIT_INIT;
                            r_state <= c_WAIT;
                        end
                    end
                end
                c_WAIT: begin
                    if (r_cnt == 4'd0)
                        r_state <= c_RESP;
                    else
                        r_cnt <= r_cnt - 4'd1;
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Stores commit on the edge leaving RESP; an async reset drops the state
    // to IDLE first, so an aborted store never reaches the array.
    always_ff @(posedge clk) begin
        if ((r_state == c_RESP) && r_rw && !w_err) begin
            case (r_size)
                2'b00: r_mem[r_addr] <= r_di[7:0];
                2'b01: begin
                    r_mem[r_addr]               <= r_di[15:8];
                    r_mem[r_addr + ADDR_W'(1)]  <= r_di[7:0];
                end
                2'b10: begin
                    r_mem[r_addr]               <= r_di[31:24];
                    r_mem[r_addr + ADDR_W'(1)]  <= r_di[23:16];
                    r_mem[r_addr + ADDR_W'(2)]  <= r_di[15:8];
                    r_mem[r_addr + ADDR_W'(3)]  <= r_di[7:0];
                end
                default: ;
            endcase
        end
    end

    assign DO    = r_do;
    assign READY = r_ready;
    assign ERR   = r_err;
    assign BUSY  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Directed bench for data_mem_responder with 1 and 3 wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_e;
    logic        sel3;
    logic        RW;
    logic [1:0]  SIZE;
    logic        SE;
    logic [8:0]  A;
    logic [31:0] DI;

    logic        e1, e3;
    logic [31:0] do1, do3;
    logic        ready1, ready3, err1, err3, busy1, busy3;
    logic [31:0] obs_do;
    logic        obs_ready, obs_err, obs_busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int          res_lat;
    int          res_nrdy;
    int          res_busy_bad;
    logic        res_err;
    logic [31:0] res_do;

    assign e1 = req_e & ~sel3;
    assign e3 = req_e & sel3;
    assign obs_do    = sel3 ? do3    : do1;
    assign obs_ready = sel3 ? ready3 : ready1;
    assign obs_err   = sel3 ? err3   : err1;
    assign obs_busy  = sel3 ? busy3  : busy1;

    data_mem_responder #(.ADDR_W(9), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .E(e1), .RW(RW), .SIZE(SIZE), .SE(SE),
        .A(A), .DI(DI), .DO(do1), .READY(ready1), .ERR(err1), .BUSY(busy1)
    );

    data_mem_responder #(.ADDR_W(9), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .E(e3), .RW(RW), .SIZE(SIZE), .SE(SE),
        .A(A), .DI(DI), .DO(do3), .READY(ready3), .ERR(err3), .BUSY(busy3)
    );

    always #5 clk = ~clk;

    // Issue one request and observe 8 cycles after the accept cycle.
    // hold keeps E high through the expected RESP cycle.
    task automatic run_req(input logic rw, input logic [1:0] size, input logic se,
                           input logic [8:0] a, input logic [31:0] di, input logic hold);
        int lat_exp;
        lat_exp = sel3 ? 4 : 2;
        @(posedge clk); #1;
        RW = rw; SIZE = size; SE = se; A = a; DI = di; req_e = 1'b1;
        @(posedge clk); #1;
        req_e = hold;
        RW = ~rw; SIZE = 2'b11; SE = ~se; A = ~a; DI = ~di;
        res_lat = -1; res_nrdy = 0; res_busy_bad = 0; res_err = 1'b0; res_do = 32'hx;
        for (int c = 1; c <= 8; c++) begin
            if (obs_ready === 1'b1) begin
                res_nrdy++;
                if (res_lat < 0) begin
                    res_lat = c;
                    res_err = obs_err;
                    res_do  = obs_do;
                end
            end
            if (obs_busy !== (c <= lat_exp)) res_busy_bad++;
            if (c >= lat_exp) req_e = 1'b0;
            @(posedge clk); #1;
        end
        req_e = 1'b0;
    endtask

    task automatic test_reset();
        int bad;
        sel3 = 1'b0;
        @(posedge clk); #1;
        total_cnt++; if ({obs_do, obs_ready, obs_err, obs_busy} !== 35'd0) $display("FAIL reset_outputs: got do=%h rdy=%b err=%b busy=%b expected all zero", obs_do, obs_ready, obs_err, obs_busy); else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            if (ready1 !== 1'b0 || busy1 !== 1'b0 || ready3 !== 1'b0 || busy3 !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        total_cnt++; if (bad !== 0) $display("FAIL reset_release_idle: got %0d active cycles expected 0", bad); else pass_cnt++;
    endtask

    task automatic test_word_byte();
        sel3 = 1'b0;
        run_req(1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, 1'b0);
        total_cnt++; if (res_lat !== 2) $display("FAIL st_word_latency: got %0d expected 2", res_lat); else pass_cnt++;
        total_cnt++; if (res_nrdy !== 1 || res_err !== 1'b0) $display("FAIL st_word_ready: got nrdy=%0d err=%b expected 1/0", res_nrdy, res_err); else pass_cnt++;
        total_cnt++; if (res_busy_bad !== 0) $display("FAIL st_word_busy: got %0d bad cycles expected 0", res_busy_bad); else pass_cnt++;
        run_req(1'b0, 2'b00, 1'b0, 9'h010, 32'h0, 1'b0);
        total_cnt++; if (res_do !== 32'h000000DE) $display("FAIL ldub_010: got %h expected 000000de", res_do); else pass_cnt++;
        run_req(1'b0, 2'b00, 1'b1, 9'h013, 32'h0, 1'b0);
        total_cnt++; if (res_do !== 32'hFFFFFFEF) $display("FAIL ldsb_013: got %h expected ffffffef", res_do); else pass_cnt++;
        run_req(1'b0, 2'b10, 1'b1, 9'h010, 32'h0, 1'b0);
        total_cnt++; if (res_do !== 32'hDEADBEEF || res_err !== 1'b0) $display("FAIL ld_010: got %h err=%b expected deadbeef", res_do, res_err); else pass_cnt++;
    endtask

    task automatic test_halfword();
        sel3 = 1'b0;
        run_req(1'b1, 2'b10, 1'b0, 9'h020, 32'h00000000, 1'b0);
        total_cnt++; if (res_do !== 32'hDEADBEEF) $display("FAIL store_holds_do: got %h expected deadbeef", res_do); else pass_cnt++;
        run_req(1'b1, 2'b01, 1'b0, 9'h020, 32'h00008001, 1'b0);
        run_req(1'b0, 2'b01, 1'b0, 9'h020, 32'h0, 1'b0);
        total_cnt++; if (res_do !== 32'h00008001) $display("FAIL lduh_020: got %h expected 00008001", res_do); else pass_cnt++;
        run_req(1'b0, 2'b01, 1'b1, 9'h020, 32'h0, 1'b0);
        total_cnt++; if (res_do !== 32'hFFFF8001) $display("FAIL ldsh_020: got %h expected ffff8001", res_do); else pass_cnt++;
        run_req(1'b0, 2'b10, 1'b0, 9'h020, 32'h0, 1'b0);
        total_cnt++; if (res_do !== 32'h80010000) $display("FAIL ld_020: got %h expected 80010000", res_do); else pass_cnt++;
    endtask

    task automatic test_byte_merge();
        sel3 = 1'b0;
        run_req(1'b1, 2'b10, 1'b0, 9'h030, 32'h11223344, 1'b0);
        run_req(1'b1, 2'b00, 1'b0, 9'h031, 32'h0000005A, 1'b0);
        run_req(1'b0, 2'b10, 1'b0, 9'h030, 32'h0, 1'b0);
        total_cnt++; if (res_do !== 32'h115A3344) $display("FAIL byte_merge: got %h expected 115a3344", res_do); else pass_cnt++;
    endtask

    task automatic test_misaligned();
        sel3 = 1'b0;
        run_req(1'b0, 2'b01, 1'b0, 9'h021, 32'h0, 1'b0);
        total_cnt++; if (res_lat !== 2 || res_err !== 1'b1 || res_do !== 32'h0) $display("FAIL lduh_021_err: got lat=%0d err=%b do=%h expected 2/1/00000000", res_lat, res_err, res_do); else pass_cnt++;
        run_req(1'b1, 2'b10, 1'b0, 9'h012, 32'hFFFFFFFF, 1'b0);
        total_cnt++; if (res_err !== 1'b1 || res_nrdy !== 1) $display("FAIL st_012_err: got err=%b nrdy=%0d expected 1/1", res_err, res_nrdy); else pass_cnt++;
        run_req(1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 1'b0);
        total_cnt++; if (res_do !== 32'hDEADBEEF) $display("FAIL ld_010_after_err: got %h expected deadbeef", res_do); else pass_cnt++;
        run_req(1'b0, 2'b11, 1'b0, 9'h000, 32'h0, 1'b0);
        total_cnt++; if (res_err !== 1'b1 || res_do !== 32'h0) $display("FAIL size11_err: got err=%b do=%h expected 1/00000000", res_err, res_do); else pass_cnt++;
    endtask

    task automatic test_wait_states();
        sel3 = 1'b1;
        run_req(1'b1, 2'b10, 1'b0, 9'h040, 32'hCAFEF00D, 1'b1);
        total_cnt++; if (res_lat !== 4 || res_nrdy !== 1) $display("FAIL wait3_store: got lat=%0d nrdy=%0d expected 4/1", res_lat, res_nrdy); else pass_cnt++;
        total_cnt++; if (res_busy_bad !== 0) $display("FAIL wait3_busy: got %0d bad cycles expected 0", res_busy_bad); else pass_cnt++;
        run_req(1'b0, 2'b10, 1'b0, 9'h040, 32'h0, 1'b0);
        total_cnt++; if (res_lat !== 4 || res_do !== 32'hCAFEF00D) $display("FAIL wait3_load: got lat=%0d do=%h expected 4/cafef00d", res_lat, res_do); else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        int n;
        sel3 = 1'b1;
        @(posedge clk); #1;
        RW = 1'b1; SIZE = 2'b10; SE = 1'b0; A = 9'h040; DI = 32'h12345678; req_e = 1'b1;
        @(posedge clk); #1;
        req_e = 1'b0;
        @(posedge clk); #1;
        total_cnt++; if (obs_busy !== 1'b1) $display("FAIL abort_busy_before: got %b expected 1", obs_busy); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if ({obs_do, obs_ready, obs_err, obs_busy} !== 35'd0) $display("FAIL async_reset: got do=%h rdy=%b err=%b busy=%b expected all zero", obs_do, obs_ready, obs_err, obs_busy); else pass_cnt++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (obs_ready === 1'b1) n++;
            @(posedge clk); #1;
        end
        total_cnt++; if (n !== 0) $display("FAIL abort_no_ready: got %0d pulses expected 0", n); else pass_cnt++;
        run_req(1'b0, 2'b10, 1'b0, 9'h040, 32'h0, 1'b0);
        total_cnt++; if (res_do !== 32'hCAFEF00D) $display("FAIL abort_no_write: got %h expected cafef00d", res_do); else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; req_e = 1'b0; sel3 = 1'b0;
        RW = 1'b0; SIZE = 2'b00; SE = 1'b0; A = '0; DI = '0;
        test_reset();
        test_word_byte();
        test_halfword();
        test_byte_merge();
        test_misaligned();
        test_wait_states();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
